// File: rtl/k12a_input_cond.sv
// Board input conditioning for the k12a: two-flop synchronisers, per-bit
// debouncers, and button press pulse / sticky press-flag generation.
module k12a_input_cond #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic [7:0] raw_switches,
  input  logic [7:0] raw_buttons,
  input  logic [7:0] press_ack,
  output logic [7:0] switches,
  output logic [7:0] buttons,
  output logic [7:0] button_press_pulse,
  output logic [7:0] button_pressed
);

  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] sync1;
  logic [15:0] sync2;
  logic [15:0] deb;
  logic [15:0] deb_next;
  logic [15:0] cnt      [16];
  logic [15:0] cnt_next [16];
  logic [7:0]  rise;

  // Bits 7:0 are switches, 15:8 are buttons.
  always_comb begin
    deb_next = deb;
    for (int i = 0; i < 16; i++) begin
      cnt_next[i] = cnt[i];
      if (sync2[i] == deb[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == LAST) begin
        deb_next[i] = sync2[i];
        cnt_next[i] = '0;
      end else begin
        cnt_next[i] = cnt[i] + 16'd1;
      end
    end
  end

  assign rise = deb_next[15:8] & ~deb[15:8];

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      sync1              <= '0;
      sync2              <= '0;
      deb                <= '0;
      button_press_pulse <= '0;
      button_pressed     <= '0;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      sync1              <= {raw_buttons, raw_switches};
      sync2              <= sync1;
      deb                <= deb_next;
      button_press_pulse <= rise;
      // A new press wins over a coincident acknowledge.
      button_pressed     <= (button_pressed & ~press_ack) | rise;
      for (int i = 0; i < 16; i++) cnt[i] <= cnt_next[i];
    end
  end

  assign switches = deb[7:0];
  assign buttons  = deb[15:8];

endmodule

// File: tb/tb_k12a_input_cond.sv
// Self-checking bench for k12a_input_cond at DEBOUNCE_CYCLES=4: fixed
// vector table, corner-case sequences, and randomized model comparison.
module tb_k12a_input_cond;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sw  = '0;
  logic [7:0] bt  = '0;
  logic [7:0] ack = '0;
  logic [7:0] o_sw, o_bt, o_pulse, o_pressed;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  k12a_input_cond #(.DEBOUNCE_CYCLES(D)) dut (
    .sys_clock          (clk),
    .reset              (rst),
    .raw_switches       (sw),
    .raw_buttons        (bt),
    .press_ack          (ack),
    .switches           (o_sw),
    .buttons            (o_bt),
    .button_press_pulse (o_pulse),
    .button_pressed     (o_pressed)
  );

  // Reference: each input is seen two clocks late; the debounced value
  // follows it once it has disagreed for D consecutive cycles.
  logic [15:0] m_s1 = '0, m_s2 = '0, m_deb = '0;
  int          m_run [16];
  logic [7:0]  m_pulse = '0, m_pressed = '0;

  task automatic model_edge(input logic r, input logic [7:0] s,
                            input logic [7:0] b, input logic [7:0] a);
    logic [15:0] nd;
    logic [7:0]  rs;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      m_pulse = '0; m_pressed = '0;
      for (int i = 0; i < 16; i++) m_run[i] = 0;
    end else begin
      nd = m_deb;
      for (int i = 0; i < 16; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            nd[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      rs = nd[15:8] & ~m_deb[15:8];
      m_pulse = rs;
      m_pressed = (m_pressed & ~a) | rs;
      m_deb = nd;
      m_s2 = m_s1;
      m_s1 = {b, s};
    end
  endtask

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] s,
                      input logic [7:0] b, input logic [7:0] a);
    @(negedge clk);
    rst = r; sw = s; bt = b; ack = a;
    @(posedge clk);
    model_edge(r, s, b, a);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".switches"}, o_sw, m_deb[7:0]);
    check({tag, ".buttons"}, o_bt, m_deb[15:8]);
    check({tag, ".pulse"}, o_pulse, m_pulse);
    check({tag, ".pressed"}, o_pressed, m_pressed);
  endtask

  typedef struct {
    logic       r;
    logic [7:0] s, b, a;
    logic [7:0] e_sw, e_bt, e_pulse, e_pressed;
  } vec_t;

  vec_t vt [16];

  initial begin
    for (int i = 0; i < 16; i++) m_run[i] = 0;

    // Reset, then 0xA5 on switches, then button 3 press and ack.
    vt[0] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 1; i <= 5; i++)
      vt[i] = '{1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[6] = '{1'b0, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
    for (int i = 7; i <= 11; i++)
      vt[i] = '{1'b0, 8'hA5, 8'h08, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
    vt[12] = '{1'b0, 8'hA5, 8'h08, 8'h00, 8'hA5, 8'h08, 8'h08, 8'h08};
    vt[13] = '{1'b0, 8'hA5, 8'h08, 8'h00, 8'hA5, 8'h08, 8'h00, 8'h08};
    vt[14] = '{1'b0, 8'hA5, 8'h08, 8'h08, 8'hA5, 8'h08, 8'h00, 8'h00};
    vt[15] = '{1'b0, 8'hA5, 8'h08, 8'h00, 8'hA5, 8'h08, 8'h00, 8'h00};

    for (int i = 0; i < 16; i++) begin
      step(vt[i].r, vt[i].s, vt[i].b, vt[i].a);
      check($sformatf("vec%0d.switches", i), o_sw, vt[i].e_sw);
      check($sformatf("vec%0d.buttons", i), o_bt, vt[i].e_bt);
      check($sformatf("vec%0d.pulse", i), o_pulse, vt[i].e_pulse);
      check($sformatf("vec%0d.pressed", i), o_pressed, vt[i].e_pressed);
    end

    // Glitch on button 0 shorter than D never reaches the outputs.
    step(1'b1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h01, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 8'h00, 8'h00);
      check("glitch.buttons", o_bt, 8'h00);
      check("glitch.pulse", o_pulse, 8'h00);
    end

    // Press of button 2 with ack on the registering edge: set wins.
    for (int i = 1; i <= 5; i++) step(1'b0, 8'h00, 8'h04, 8'h00);
    check("setwin.before", o_pressed, 8'h00);
    step(1'b0, 8'h00, 8'h04, 8'h04);
    check("setwin.pulse", o_pulse, 8'h04);
    check("setwin.pressed", o_pressed, 8'h04);
    step(1'b0, 8'h00, 8'h04, 8'h00);
    check("setwin.hold", o_pressed, 8'h04);

    // Reset mid-count on switch 7 restarts the full latency.
    step(1'b1, 8'h00, 8'h00, 8'h00);
    step(1'b0, 8'h80, 8'h00, 8'h00);
    step(1'b0, 8'h80, 8'h00, 8'h00);
    step(1'b1, 8'h80, 8'h00, 8'hFF);
    check("midrst.pressed", o_pressed, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 8'h80, 8'h00, 8'h00);
      check($sformatf("midrst.early%0d", i), o_sw, 8'h00);
    end
    step(1'b0, 8'h80, 8'h00, 8'h00);
    check("midrst.rise", o_sw, 8'h80);

    // All buttons held through reset: one pulse of 0xFF after latency.
    step(1'b1, 8'h00, 8'hFF, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 8'h00, 8'hFF, 8'h00);
      check("all.nopulse", o_pulse, 8'h00);
    end
    step(1'b0, 8'h00, 8'hFF, 8'h00);
    check("all.pulse", o_pulse, 8'hFF);
    check("all.pressed", o_pressed, 8'hFF);
    step(1'b0, 8'h00, 8'hFF, 8'h20);
    check("all.pulse_end", o_pulse, 8'h00);
    check("all.ack_one", o_pressed, 8'hDF);
    check_model("all");

    // Randomized: slowly changing inputs, sparse resets and acks.
    begin
      logic [7:0] rs, rb, ra;
      logic       rr;
      rs = '0; rb = '0;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(7) == 0) rs = rs ^ 8'($urandom());
        if ($urandom_range(5) == 0) rb = rb ^ 8'($urandom());
        ra = ($urandom_range(3) == 0) ? 8'($urandom()) : 8'h00;
        rr = ($urandom_range(99) == 0);
        step(rr, rs, rb, ra);
        check_model($sformatf("rand%0d", c));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
